// File: rtl/arb_gnt_fifo.sv
// Grant-capture FWFT FIFO between the round-robin arbiter and the next stage; throttles the arbiter via arb_en.
// Optional statistics outputs (gnt_cnt, occ_max) are enabled by defining ARB_GNT_FIFO_STATS_EN.
module arb_gnt_fifo #(
   parameter int NUM_SRC   = 20,
   parameter int SRC_NBITS = 5,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int PTR_NBITS = 3
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        arb_gnt,
   input  logic [SRC_NBITS-1:0]        arb_sel,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   output logic                        arb_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [SRC_NBITS-1:0]        out_src,
   output logic [PTR_NBITS:0]          occ,
   output logic                        ovf
`ifdef ARB_GNT_FIFO_STATS_EN
   ,
   output logic [31:0]                 gnt_cnt,
   output logic [PTR_NBITS:0]          occ_max
`endif
);

   localparam int ENTRY_W = SRC_NBITS + DATA_W;
   localparam logic [PTR_NBITS:0] FULL_LVL = (PTR_NBITS+1)'(DEPTH);
   // Headroom of 3: grant in flight plus wrap-side grants the arbiter issues while en=0.
   localparam logic [PTR_NBITS:0] EN_LVL   = (PTR_NBITS+1)'(DEPTH - 3);
   localparam logic [PTR_NBITS:0] ONE_LVL  = (PTR_NBITS+1)'(1);

   logic [ENTRY_W-1:0]   mem_r [DEPTH];
   logic [PTR_NBITS:0]   wptr_r;
   logic [PTR_NBITS:0]   rptr_r;
   logic [PTR_NBITS:0]   occ_r;
   logic                 out_valid_r;
   logic [DATA_W-1:0]    out_data_r;
   logic [SRC_NBITS-1:0] out_src_r;
   logic                 arb_en_r;
   logic                 ovf_r;

   logic                 full_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 ovf_evt_s;
   logic [DATA_W-1:0]    wr_data_s;
   logic [PTR_NBITS:0]   wptr_nxt_s;
   logic [PTR_NBITS:0]   rptr_nxt_s;
   logic [PTR_NBITS:0]   occ_nxt_s;
   logic [ENTRY_W-1:0]   head_nxt_s;

   // Push/pop decode, next pointers, next occupancy and next head entry.
   always_comb begin
      full_s     = (occ_r == FULL_LVL);
      pop_s      = out_valid_r & out_ready;
      push_s     = arb_gnt & (~full_s | pop_s);
      ovf_evt_s  = arb_gnt & full_s & ~pop_s;
      wr_data_s  = '0;
      wptr_nxt_s = wptr_r;
      rptr_nxt_s = rptr_r;
      occ_nxt_s  = occ_r;
      head_nxt_s = {out_src_r, out_data_r};

      if (32'(arb_sel) < 32'(NUM_SRC)) begin
         wr_data_s = src_data[32'(arb_sel)*DATA_W +: DATA_W];
      end else begin
         wr_data_s = '0;
      end

      if (push_s) begin
         wptr_nxt_s = wptr_r + ONE_LVL;
      end else begin
         wptr_nxt_s = wptr_r;
      end

      if (pop_s) begin
         rptr_nxt_s = rptr_r + ONE_LVL;
      end else begin
         rptr_nxt_s = rptr_r;
      end

      case ({push_s, pop_s})
         2'b10:   occ_nxt_s = occ_r + ONE_LVL;
         2'b01:   occ_nxt_s = occ_r - ONE_LVL;
         default: occ_nxt_s = occ_r;
      endcase

      // The new entry becomes the head when nothing older survives this cycle.
      if (occ_nxt_s == '0) begin
         head_nxt_s = {out_src_r, out_data_r};
      end else if (push_s && ((occ_r == '0) || ((occ_r == ONE_LVL) && pop_s))) begin
         head_nxt_s = {arb_sel, wr_data_s};
      end else begin
         head_nxt_s = mem_r[rptr_nxt_s[PTR_NBITS-1:0]];
      end
   end

   // Storage, pointers, occupancy and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wptr_r      <= '0;
         rptr_r      <= '0;
         occ_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_src_r   <= '0;
         arb_en_r    <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wptr_r[PTR_NBITS-1:0]] <= {arb_sel, wr_data_s};
         end
         wptr_r                  <= wptr_nxt_s;
         rptr_r                  <= rptr_nxt_s;
         occ_r                   <= occ_nxt_s;
         out_valid_r             <= (occ_nxt_s != '0);
         {out_src_r, out_data_r} <= head_nxt_s;
         arb_en_r                <= (occ_nxt_s <= EN_LVL);
         if (ovf_evt_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign arb_en    = arb_en_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_src   = out_src_r;
   assign occ       = occ_r;
   assign ovf       = ovf_r;

`ifdef ARB_GNT_FIFO_STATS_EN
   logic [31:0]        gnt_cnt_r;
   logic [PTR_NBITS:0] occ_max_r;

   // Accepted-push counter and occupancy high-water mark.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt_cnt_r <= 32'd0;
         occ_max_r <= '0;
      end else begin
         gnt_cnt_r <= gnt_cnt_r + 32'(push_s);
         if (occ_nxt_s > occ_max_r) begin
            occ_max_r <= occ_nxt_s;
         end
      end
   end

   assign gnt_cnt = gnt_cnt_r;
   assign occ_max = occ_max_r;
`endif

endmodule
